// File: rtl/step_clk_ctrl.sv
// step_clk_ctrl: CPU execution clock-enable generator.
// Single-steps from a debounced push-button; with STEP_CLK_AUTORUN_EN defined
// it also free-runs while sw_run is held. Counts issued clk_on pulses.
module step_clk_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PULSE_CYCLES    = 5,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        sw_run,
  output logic        clk_on,
  output logic        busy,
  output logic [31:0] pulse_cnt
);

  localparam int unsigned      PH_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_nx;
  logic [PH_W-1:0]  ph, ph_nx;
  logic             btn_s1, btn_sync;
  logic             btn_db, btn_db_q;
  logic [CNT_W-1:0] db_cnt;
  logic             step_ev;
  logic             run_sync;
  logic             enter_high;

  // Two-flop synchronizer for the step button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_s1   <= btn_step;
      btn_sync <= btn_s1;
    end
  end

`ifdef STEP_CLK_AUTORUN_EN
  logic run_s1;

  // Two-flop synchronizer for the free-run switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_s1   <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_s1   <= sw_run;
      run_sync <= run_s1;
    end
  end
`else
  logic unused_sw_run;
  assign unused_sw_run = sw_run;
  assign run_sync      = 1'b0;
`endif

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  assign step_ev = btn_db & ~btn_db_q;

  // Next-state and phase counter; events outside IDLE are simply not looked at
  always_comb begin
    state_nx = state;
    ph_nx    = ph + PH_W'(1);
    case (state)
      IDLE: begin
        ph_nx = '0;
        if (step_ev || run_sync) state_nx = HIGH;
      end
      HIGH: begin
        if (ph == PH_LAST) begin
          state_nx = LOW;
          ph_nx    = '0;
        end
      end
      LOW: begin
        if (ph == PH_LAST) begin
          state_nx = run_sync ? HIGH : IDLE;
          ph_nx    = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        ph_nx    = '0;
      end
    endcase
  end

  assign enter_high = (state_nx == HIGH) && (state != HIGH);

  // State, phase, registered clk_on and pulse counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ph        <= '0;
      clk_on    <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state     <= state_nx;
      ph        <= ph_nx;
      clk_on    <= (state_nx == HIGH);
      pulse_cnt <= pulse_cnt + {31'd0, enter_high};
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Self-checking bench for step_clk_ctrl (DEBOUNCE_CYCLES=4, PULSE_CYCLES=5).
module tb_step_clk_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned PC = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_step = 1'b0;
  logic        sw_run = 1'b0;
  logic        clk_on;
  logic        busy;
  logic [31:0] pulse_cnt;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  step_clk_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES   (PC),
    .CNT_W          (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_step (btn_step),
    .sw_run   (sw_run),
    .clk_on   (clk_on),
    .busy     (busy),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: button delay line, run-length debounce, and a pulse
  // timeline m_t (-1 idle, 0..2*PC-1 position inside the current pulse).
  logic        m_s1, m_s2, m_r1, m_r2, m_db, m_rise;
  int          m_run;
  int          m_t;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_r1 = 0; m_r2 = 0; m_db = 0; m_rise = 0;
    m_run = 0; m_t = -1; m_cnt = '0;
  endtask

  task automatic model_edge();
    logic pre_sync, pre_run, pre_rise;
    pre_sync = m_s2;
    pre_run  = m_r2;
    pre_rise = m_rise;
    if (m_t >= 0) begin
      m_t++;
      if (m_t == int'(2 * PC)) begin
        if (pre_run) begin
          m_t = 0;
          m_cnt++;
        end else begin
          m_t = -1;
        end
      end
    end else if (pre_rise || pre_run) begin
      m_t = 0;
      m_cnt++;
    end
    m_rise = 0;
    if (pre_sync != m_db) begin
      m_run++;
      if (m_run == int'(DB)) begin
        m_db   = pre_sync;
        m_run  = 0;
        m_rise = pre_sync;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn_step;
    m_r2 = m_r1;
`ifdef STEP_CLK_AUTORUN_EN
    m_r1 = sw_run;
`else
    m_r1 = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_clk_on", {31'd0, clk_on}, {31'd0, (m_t >= 0 && m_t < int'(PC))});
    chk("model_busy",   {31'd0, busy},   {31'd0, (m_t >= 0)});
    chk("model_cnt",    pulse_cnt,       m_cnt);
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic expect_out(input string name, input logic e_clk, input logic e_busy,
                            input logic [31:0] e_cnt);
    chk({name, "_clk_on"}, {31'd0, clk_on}, {31'd0, e_clk});
    chk({name, "_busy"},   {31'd0, busy},   {31'd0, e_busy});
    chk({name, "_cnt"},    pulse_cnt,       e_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_step = 1'b0;
    sw_run = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        btn;
    int unsigned n;
    logic        e_clk;
    logic        e_busy;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] c0;
  int unsigned rises;
  logic        prev_on;
  bit          seen;

  initial begin
    // Clean press then bounce; each row: drive btn, wait n edges, check outputs
    tbl.push_back('{1'b1, 6,  1'b0, 1'b0, 32'd0});
    tbl.push_back('{1'b1, 1,  1'b1, 1'b1, 32'd1});
    tbl.push_back('{1'b1, 4,  1'b1, 1'b1, 32'd1});
    tbl.push_back('{1'b1, 1,  1'b0, 1'b1, 32'd1});
    tbl.push_back('{1'b0, 4,  1'b0, 1'b1, 32'd1});
    tbl.push_back('{1'b0, 1,  1'b0, 1'b0, 32'd1});
    tbl.push_back('{1'b0, 10, 1'b0, 1'b0, 32'd1});
    tbl.push_back('{1'b1, 1,  1'b0, 1'b0, 32'd1});
    tbl.push_back('{1'b0, 1,  1'b0, 1'b0, 32'd1});
    tbl.push_back('{1'b1, 1,  1'b0, 1'b0, 32'd1});
    tbl.push_back('{1'b0, 1,  1'b0, 1'b0, 32'd1});
    tbl.push_back('{1'b1, 1,  1'b0, 1'b0, 32'd1});
    tbl.push_back('{1'b1, 5,  1'b0, 1'b0, 32'd1});
    tbl.push_back('{1'b1, 1,  1'b1, 1'b1, 32'd2});
    tbl.push_back('{1'b1, 9,  1'b0, 1'b1, 32'd2});
    tbl.push_back('{1'b1, 1,  1'b0, 1'b0, 32'd2});
    tbl.push_back('{1'b0, 12, 1'b0, 1'b0, 32'd2});

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      btn_step = tbl[i].btn;
      ticks(tbl[i].n);
      expect_out($sformatf("vec%0d", i), tbl[i].e_clk, tbl[i].e_busy, tbl[i].e_cnt);
    end

    // Second step event lands in the first IDLE cycle: accepted
    c0 = pulse_cnt;
    btn_step = 1'b1; ticks(7);
    expect_out("acc_first", 1'b1, 1'b1, c0 + 1);
    btn_step = 1'b0; ticks(4);
    expect_out("acc_high_end", 1'b1, 1'b1, c0 + 1);
    btn_step = 1'b1; ticks(6);
    expect_out("acc_idle", 1'b0, 1'b0, c0 + 1);
    tick();
    expect_out("acc_second", 1'b1, 1'b1, c0 + 2);
    ticks(9);
    expect_out("acc_low_end", 1'b0, 1'b1, c0 + 2);
    tick();
    expect_out("acc_done", 1'b0, 1'b0, c0 + 2);
    btn_step = 1'b0; ticks(12);

    // Second step event lands in the last LOW cycle: dropped
    c0 = pulse_cnt;
    btn_step = 1'b1; ticks(6);
    btn_step = 1'b0; ticks(4);
    btn_step = 1'b1; ticks(6);
    expect_out("drop_low", 1'b0, 1'b1, c0 + 1);
    tick();
    expect_out("drop_idle", 1'b0, 1'b0, c0 + 1);
    ticks(8);
    expect_out("drop_stay", 1'b0, 1'b0, c0 + 1);
    btn_step = 1'b0; ticks(12);

    // Counter wrap: hold the forced value across one edge so it sticks
    @(negedge clk);
    force dut.pulse_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    release dut.pulse_cnt;
    #1;
    chk("wrap_preset", pulse_cnt, 32'hFFFF_FFFF);
    btn_step = 1'b1; ticks(7);
    expect_out("wrap", 1'b1, 1'b1, 32'h0000_0000);
    ticks(10);
    btn_step = 1'b0; ticks(12);

    // Asynchronous reset in the middle of HIGH
    btn_step = 1'b1; ticks(9);
    chk("pre_rst_clk_on", {31'd0, clk_on}, 32'd1);
    btn_step = 1'b0;
    rst = 1'b1;
    #1;
    expect_out("rst_mid", 1'b0, 1'b0, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1'b0;
    ticks(12);

`ifdef STEP_CLK_AUTORUN_EN
    // Free run: first rise after the 2-flop synchronizer, then 10-cycle period
    sw_run = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (clk_on) seen = 1;
    end
    chk("run_start", {31'd0, seen}, 32'd1);
    rises = 0;
    prev_on = clk_on;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (clk_on && !prev_on) rises++;
      prev_on = clk_on;
    end
    chk("run_rises", rises, 32'd10);
    // Align to a fresh HIGH entry, then drop the switch two cycles in
    seen = 0;
    prev_on = clk_on;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (clk_on && !prev_on) seen = 1;
      prev_on = clk_on;
    end
    chk("run_align", {31'd0, seen}, 32'd1);
    c0 = pulse_cnt;
    ticks(2);
    sw_run = 1'b0;
    ticks(2);
    expect_out("stop_high", 1'b1, 1'b1, c0);
    ticks(5);
    expect_out("stop_low", 1'b0, 1'b1, c0);
    tick();
    expect_out("stop_idle", 1'b0, 1'b0, c0);
    ticks(10);
    expect_out("stop_stay", 1'b0, 1'b0, c0);
`endif

    // Randomized hold lengths on both raw inputs, checked against the model
    for (int s = 0; s < 300; s++) begin
      btn_step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) sw_run = ~sw_run;
      ticks($urandom_range(1, 14));
    end
    sw_run = 1'b0;
    btn_step = 1'b0;
    ticks(30);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
